// File: rtl/pipeline_hazard_ctrl.sv
// IF/ID and PC sequencing: load-use stalls, taken-branch flushes, memory-wait freezes.
// Optional HAZARD_PERF_EN adds saturating stall/flush/freeze event counters.
module pipeline_hazard_ctrl #(
    parameter int LU_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES    = 1,
    parameter int CNT_W           = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
`ifdef HAZARD_PERF_EN
    output logic [31:0] stall_count,
    output logic [31:0] flush_count,
    output logic [31:0] freeze_count,
`endif
    output logic [1:0]  hz_state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2
    } hz_state_t;

    // cnt holds the number of further cycles to spend in a state after the current one
    localparam logic [CNT_W-1:0] LU_INIT = (LU_STALL_CYCLES > 1) ? CNT_W'(LU_STALL_CYCLES - 2) : '0;
    localparam logic [CNT_W-1:0] FL_INIT = (FLUSH_CYCLES > 1) ? CNT_W'(FLUSH_CYCLES - 2) : '0;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    hz_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lu;

    assign lu = ex_mem_read && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    assign hz_state = reset ? RUN : state;

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        state_nxt    = state;
        cnt_nxt      = cnt;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_nxt    = RUN;
            cnt_nxt      = '0;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (state == FLUSH) begin
            // ID holds a flushed NOP, so a branch here cannot be real
            if_id_flush = 1'b1;
            if (cnt == '0) state_nxt = RUN;
            else           cnt_nxt   = cnt - ONE;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            cnt_nxt     = FL_INIT;
            state_nxt   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (state == LU_STALL || lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (state == LU_STALL) begin
                if (cnt == '0) state_nxt = RUN;
                else           cnt_nxt   = cnt - ONE;
            end else begin
                cnt_nxt   = LU_INIT;
                state_nxt = (LU_STALL_CYCLES > 1) ? LU_STALL : RUN;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count  <= '0;
            flush_count  <= '0;
            freeze_count <= '0;
        end else begin
            if (id_ex_bubble && !mem_busy && stall_count != 32'hFFFF_FFFF)
                stall_count <= stall_count + 32'd1;
            if (if_id_flush && flush_count != 32'hFFFF_FFFF)
                flush_count <= flush_count + 32'd1;
            if (mem_busy && freeze_count != 32'hFFFF_FFFF)
                freeze_count <= freeze_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Two differently parameterised controllers driven in lockstep, checked against a remaining-cycles model.
module tb_pipeline_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset, id_uses_rt, ex_mem_read, branch_taken, mem_busy;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       pc_w[2], ifid_w[2], flush[2], bubble[2];
    logic [1:0] hz[2];
`ifdef HAZARD_PERF_EN
    logic [31:0] st_cnt[2], fl_cnt[2], fz_cnt[2];
    int          m_st[2], m_fl[2], m_fz[2];
`endif

    int vectors = 0;
    int miscompares = 0;
    int lu_rem[2] = '{0, 0};
    int fl_rem[2] = '{0, 0};
    int LU[2] = '{2, 3};
    int FL[2] = '{3, 1};

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.LU_STALL_CYCLES(2), .FLUSH_CYCLES(3), .CNT_W(3)) dut_a (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_w[0]), .if_id_write(ifid_w[0]), .if_id_flush(flush[0]), .id_ex_bubble(bubble[0]),
`ifdef HAZARD_PERF_EN
        .stall_count(st_cnt[0]), .flush_count(fl_cnt[0]), .freeze_count(fz_cnt[0]),
`endif
        .hz_state(hz[0]));

    pipeline_hazard_ctrl #(.LU_STALL_CYCLES(3), .FLUSH_CYCLES(1), .CNT_W(3)) dut_b (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_w[1]), .if_id_write(ifid_w[1]), .if_id_flush(flush[1]), .id_ex_bubble(bubble[1]),
`ifdef HAZARD_PERF_EN
        .stall_count(st_cnt[1]), .flush_count(fl_cnt[1]), .freeze_count(fz_cnt[1]),
`endif
        .hz_state(hz[1]));

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    // Load-use hazard as the ID/EX register rules define it
    function automatic bit is_lu();
        if (!ex_mem_read || ex_rt == 5'd0) return 0;
        return (ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt);
    endfunction

    task automatic step(input bit rst, input bit mr, input int ert, input int rs, input int rt,
                        input bit urt, input bit br, input bit mb);
        bit pw, iw, fl, bb;
        int hs;
        @(negedge clock);
        reset = rst; ex_mem_read = mr; ex_rt = 5'(ert); id_rs = 5'(rs); id_rt = 5'(rt);
        id_uses_rt = urt; branch_taken = br; mem_busy = mb;
        #1;
        vectors++;
        for (int i = 0; i < 2; i++) begin
            hs = (fl_rem[i] > 0) ? 2 : (lu_rem[i] > 0) ? 1 : 0;
            if (rst) begin
                {pw, iw, fl, bb} = 4'b0011; hs = 0;
                lu_rem[i] = 0; fl_rem[i] = 0;
            end else if (mb) begin
                {pw, iw, fl, bb} = 4'b0000;
            end else if (fl_rem[i] > 0) begin
                {pw, iw, fl, bb} = 4'b1110; fl_rem[i]--;
            end else if (br) begin
                {pw, iw, fl, bb} = 4'b1110; fl_rem[i] = FL[i] - 1; lu_rem[i] = 0;
            end else if (lu_rem[i] > 0) begin
                {pw, iw, fl, bb} = 4'b0001; lu_rem[i]--;
            end else if (is_lu()) begin
                {pw, iw, fl, bb} = 4'b0001; lu_rem[i] = LU[i] - 1;
            end else begin
                {pw, iw, fl, bb} = 4'b1100;
            end
            chk("pc_write", i, 32'(pc_w[i]), 32'(pw));
            chk("if_id_write", i, 32'(ifid_w[i]), 32'(iw));
            chk("if_id_flush", i, 32'(flush[i]), 32'(fl));
            chk("id_ex_bubble", i, 32'(bubble[i]), 32'(bb));
            chk("hz_state", i, 32'(hz[i]), 32'(hs));
`ifdef HAZARD_PERF_EN
            chk("stall_count", i, st_cnt[i], 32'(m_st[i]));
            chk("flush_count", i, fl_cnt[i], 32'(m_fl[i]));
            chk("freeze_count", i, fz_cnt[i], 32'(m_fz[i]));
            if (rst) begin
                m_st[i] = 0; m_fl[i] = 0; m_fz[i] = 0;
            end else begin
                m_st[i] += int'(bb && !mb);
                m_fl[i] += int'(fl);
                m_fz[i] += int'(mb);
            end
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
`ifdef HAZARD_PERF_EN
        for (int i = 0; i < 2; i++) begin m_st[i] = 0; m_fl[i] = 0; m_fz[i] = 0; end
`endif
        // reset held 3 cycles, then free running
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // load-use on rs, then the same with $0 as destination
        step(0, 1, 8, 8, 0, 0, 0, 0);
        idle(4);
        step(0, 1, 0, 0, 0, 1, 0, 0);
        idle(1);
        // load-use on rt, and rt match ignored when rt is not a source
        step(0, 1, 5, 1, 5, 1, 0, 0);
        idle(4);
        step(0, 1, 5, 1, 5, 0, 0, 0);
        idle(1);
        // single-cycle branch pulse
        step(0, 0, 0, 0, 0, 0, 1, 0);
        idle(4);
        // stall frozen by a 4-cycle memory wait in its second cycle
        step(0, 1, 8, 8, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, 0, 1);
        idle(4);
        // branch and load-use together, then reset in the middle of the flush
        step(0, 1, 8, 8, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // branch arriving during a load-use stall
        step(0, 1, 3, 3, 0, 0, 0, 0);
        step(0, 1, 3, 3, 0, 0, 1, 0);
        idle(4);
        // randomized traffic over a small register set to make matches likely
        for (int k = 0; k < 600; k++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the IF/ID pipeline register and the program counter of the 5-stage MIPS pipeline.
- Each cycle it decides whether PC and IF/ID advance, stall or flush, and whether a bubble enters ID/EX.
- Handles load-use hazards, taken-branch flushes and data-memory wait freezes with programmable multi-cycle durations.
- Sits beside IF_ID; its outputs gate the PC write and the IF/ID write/clear.

Parameters:
- LU_STALL_CYCLES, 1, cycles of load-use stall per hazard (1..7; use 2 when no forwarding unit is present).
- FLUSH_CYCLES, 1, cycles if_id_flush is held after a taken branch (1..7).
- CNT_W, 3, width of the internal duration counter.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rt  in  5  destination register of the load in EX.
- branch_taken  in  1  branch/jump resolved taken this cycle.
- mem_busy  in  1  data memory not ready; whole pipeline must freeze.
- pc_write  out  1  PC may load its next value.
- if_id_write  out  1  IF/ID may capture a new instruction and PC.
- if_id_flush  out  1  IF/ID loads a NOP (all-zero instruction).
- id_ex_bubble  out  1  ID/EX control fields are zeroed.
- hz_state  out  2  current FSM state (debug).

Behaviour:
- Hazard term: lu = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- States: RUN=0, LU_STALL=1, FLUSH=2. Register cnt is CNT_W bits wide.
- Control outputs are combinational from state and inputs. State and cnt update on the rising edge of clock.
- Reset:
  - While reset=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, hz_state=RUN.
  - On the edge: state<=RUN, cnt<=0.
  - A reset in the middle of a stall or flush aborts it; the next cycle is RUN with no residual stall.
- Priority, highest first: reset > mem_busy > branch_taken > lu.
- mem_busy=1, any state:
  - Outputs pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0.
  - state and cnt hold. Branch and lu are ignored that cycle and re-evaluated when mem_busy drops.
- RUN:
  - branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, bubble=0. If FLUSH_CYCLES>1, next=FLUSH with cnt=FLUSH_CYCLES-2; else stay in RUN.
  - lu (no branch): pc_write=0, if_id_write=0, flush=0, bubble=1. If LU_STALL_CYCLES>1, next=LU_STALL with cnt=LU_STALL_CYCLES-2; else stay in RUN.
  - Neither: pc_write=1, if_id_write=1, flush=0, bubble=0.
- LU_STALL:
  - Outputs as for lu in RUN, regardless of lu.
  - If cnt==0, next=RUN; else cnt-1.
  - branch_taken in LU_STALL aborts the stall. Outputs are the RUN branch response and the FLUSH entry follows the RUN rules.
- FLUSH:
  - pc_write=1, if_id_write=1, if_id_flush=1, bubble=0.
  - branch_taken is ignored, because ID holds a flushed NOP.
  - If cnt==0, next=RUN; else cnt-1.
- Latency: zero-cycle response; a hazard present in cycle N gates the edge ending cycle N.
- Total stall length for one load-use hazard is exactly LU_STALL_CYCLES non-frozen cycles. Flush length is exactly FLUSH_CYCLES non-frozen cycles. Freeze cycles extend both without consuming cnt.
- Register $0 never causes a load-use stall.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined:
  - Adds output ports stall_count (32-bit), flush_count (32-bit) and freeze_count (32-bit).
  - Each increments by 1 on every non-reset cycle where, respectively, id_ex_bubble=1 & mem_busy=0, if_id_flush=1 & reset=0, or mem_busy=1.
  - All counters saturate at 32'hFFFF_FFFF and clear to 0 on reset.
- When not defined: the ports and logic are absent, and control behaviour is identical.

Test Plan:
- Reset held 3 cycles, then released with no hazards -> outputs 0,0,1,1 during reset; from the next cycle pc_write=1, if_id_write=1, flush=0, bubble=0, hz_state=0.
- ex_mem_read=1, ex_rt=8, id_rs=8, LU_STALL_CYCLES=2 -> exactly 2 cycles of pc_write=0, if_id_write=0, bubble=1, then RUN; repeat with ex_rt=0 -> no stall.
- branch_taken pulsed 1 cycle, FLUSH_CYCLES=3 -> if_id_flush=1 for exactly 3 cycles with pc_write=1, then 0.
- lu stall (LU_STALL_CYCLES=3) with mem_busy=1 asserted for 4 cycles during the 2nd stall cycle -> all four controls 0 while frozen; the stall then completes its remaining 2 cycles.
- branch_taken=1 and lu=1 in the same RUN cycle -> flush response, bubble=0; reset asserted during FLUSH with cnt=1 -> next cycle after reset is RUN, flush=0.
- HAZARD_PERF_EN defined, run the two previous scenarios -> stall_count, flush_count and freeze_count match the cycle counts; reset clears them to 0.
